// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: multi-cycle FSM owning the PC; fetches, decodes branch/jump and commits one next-PC per instruction.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  BEQ_OP   = 6'b000100,
  parameter logic [5:0]  BNE_OP   = 6'b000101,
  parameter logic [5:0]  J_OP     = 6'b000010
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        Zero,
  input  logic        ZeroValid,
  output logic [31:0] PC,
  output logic        PCSrc
);
  typedef enum logic [2:0] {FETCH, WAIT_MEM, DECODE, WAIT_ZERO, UPDATE} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, npc_q, npc_d, instr_q, pc4, bt, jt;
  logic        src_q, src_d, pcsrc_q, taken, is_br;
  logic [5:0]  op;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state_q <= FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = WAIT_MEM;
      WAIT_MEM:  state_d = IMemReady ? DECODE : WAIT_MEM;
      DECODE:    state_d = is_br ? WAIT_ZERO : UPDATE;
      WAIT_ZERO: state_d = ZeroValid ? UPDATE : WAIT_ZERO;
      UPDATE:    state_d = Stall ? UPDATE : FETCH;
      default:   state_d = FETCH;
    endcase
  end
  always_comb begin
    op    = instr_q[31:26];
    is_br = (op == BEQ_OP) || (op == BNE_OP);
    pc4   = pc_q + 32'd4;
    bt    = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jt    = {pc4[31:28], instr_q[25:0], 2'b00};
    taken = (op == BEQ_OP) ? Zero : ~Zero;
    npc_d = npc_q;
    src_d = src_q;
    if (state_q == DECODE) begin
      npc_d = (op == J_OP) ? jt : pc4;
      src_d = (op == J_OP);
    end else if (state_q == WAIT_ZERO && ZeroValid) begin
      npc_d = taken ? bt : pc4;
      src_d = taken;
    end
  end
  // PC and PCSrc commit together, only when UPDATE releases to FETCH
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      instr_q <= 32'd0;
      src_q   <= 1'b0;
      pcsrc_q <= 1'b0;
    end else begin
      npc_q <= npc_d;
      src_q <= src_d;
      if (state_q == WAIT_MEM && IMemReady) instr_q <= IMemData;
      if (state_q == UPDATE && !Stall) begin
        pc_q    <= npc_q;
        pcsrc_q <= src_q;
      end
    end
  // The request is gated by Reset so it drops the instant reset is asserted
  always_comb begin
    IMemReq    = Reset && (state_q == FETCH || state_q == WAIT_MEM);
    IMemAddr   = pc_q;
    InstrValid = (state_q == DECODE);
    Instr      = instr_q;
    PC         = pc_q;
    PCSrc      = pcsrc_q;
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: drives two instances (reset PC 0 and 4000_0000) in lockstep against an instruction-level PC model.
module tb_pc_fetch_sequencer;
  logic        Clk = 0, Reset = 0, Stall = 0, IMemReady = 0, Zero = 0, ZeroValid = 0;
  logic [31:0] IMemData = 0;
  logic        req, iv, src, req_j, iv_j, src_j;
  logic [31:0] addr, ins_o, pc, addr_j, ins_o_j, pc_j;
  int checks = 0, failures = 0;
  logic [31:0] mpc, mpcj;
  logic        msrc;

  pc_fetch_sequencer dut (.Clk(Clk), .Reset(Reset), .Stall(Stall), .IMemReq(req), .IMemAddr(addr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Instr(ins_o), .InstrValid(iv), .Zero(Zero),
    .ZeroValid(ZeroValid), .PC(pc), .PCSrc(src));
  pc_fetch_sequencer #(.RESET_PC(32'h4000_0000)) dut_j (.Clk(Clk), .Reset(Reset), .Stall(Stall),
    .IMemReq(req_j), .IMemAddr(addr_j), .IMemReady(IMemReady), .IMemData(IMemData), .Instr(ins_o_j),
    .InstrValid(iv_j), .Zero(Zero), .ZeroValid(ZeroValid), .PC(pc_j), .PCSrc(src_j));

  always #5 Clk = ~Clk;

  // Instruction-level semantics: returns {branch_or_jump_taken, next_pc}
  function automatic logic [32:0] ref_next(input logic [31:0] p, input logic [31:0] ins, input logic z);
    logic [31:0] p4, tgt, jlo;
    int off;
    p4  = p + 32'd4;
    off = $signed(ins[15:0]) * 4;
    tgt = p4 + 32'(off);
    jlo = {6'd0, ins[25:0]} * 32'd4;
    case (ins[31:26])
      6'b000100: return z ? {1'b1, tgt} : {1'b0, p4};
      6'b000101: return !z ? {1'b1, tgt} : {1'b0, p4};
      6'b000010: return {1'b1, (p4 & 32'hF000_0000) | jlo};
      default:   return {1'b0, p4};
    endcase
  endfunction

  function automatic bit is_branch(input logic [31:0] ins);
    return ins[31:26] == 6'b000100 || ins[31:26] == 6'b000101;
  endfunction

  // Called at a negedge with both DUTs in FETCH; returns at the negedge of the next FETCH.
  task automatic do_instr(input logic [31:0] ins, input int mw, input int zw, input logic z, input int st);
    logic [32:0] r, rj;
    logic [31:0] old, oldj;
    r = ref_next(mpc, ins, z);
    rj = ref_next(mpcj, ins, z);
    old = mpc; oldj = mpcj;
    checks++;
    if (req !== 1'b1 || req_j !== 1'b1 || addr !== mpc || addr_j !== mpcj || iv !== 1'b0) begin
      failures++;
      $display("FAIL fetch: req=%b/%b addr=%h/%h iv=%b required req=1 addr=%h/%h iv=0", req, req_j, addr, addr_j, iv, mpc, mpcj);
    end
    IMemReady = 1'($urandom); ZeroValid = 1'($urandom); Zero = 1'($urandom); Stall = 1'($urandom);
    @(negedge Clk);
    for (int i = 0; i < mw; i++) begin
      IMemReady = 0; IMemData = $urandom; Stall = 1'($urandom); ZeroValid = 1'($urandom);
      checks++;
      if (req !== 1'b1 || iv !== 1'b0 || pc !== old) begin
        failures++;
        $display("FAIL wait_mem: req=%b iv=%b pc=%h required req=1 iv=0 pc=%h", req, iv, pc, old);
      end
      @(negedge Clk);
    end
    IMemReady = 1; IMemData = ins;
    @(negedge Clk);
    IMemReady = 1'($urandom); IMemData = $urandom; ZeroValid = 1'($urandom); Stall = 1'($urandom);
    checks++;
    if (iv !== 1'b1 || iv_j !== 1'b1 || ins_o !== ins || ins_o_j !== ins || req !== 1'b0) begin
      failures++;
      $display("FAIL decode: iv=%b/%b instr=%h/%h req=%b required iv=1 instr=%h req=0", iv, iv_j, ins_o, ins_o_j, req, ins);
    end
    @(negedge Clk);
    if (is_branch(ins)) begin
      for (int i = 0; i < zw; i++) begin
        ZeroValid = 0; Zero = 1'($urandom); IMemReady = 1'($urandom); Stall = 1'($urandom);
        checks++;
        if (iv !== 1'b0 || req !== 1'b0 || pc !== old) begin
          failures++;
          $display("FAIL wait_zero: iv=%b req=%b pc=%h required iv=0 req=0 pc=%h", iv, req, pc, old);
        end
        @(negedge Clk);
      end
      ZeroValid = 1; Zero = z;
      @(negedge Clk);
    end
    ZeroValid = 1'($urandom); Zero = 1'($urandom); IMemReady = 1'($urandom);
    for (int i = 0; i < st; i++) begin
      Stall = 1;
      checks++;
      if (pc !== old || pc_j !== oldj || req !== 1'b0 || iv !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: pc=%h/%h req=%b iv=%b required pc=%h/%h req=0 iv=0", pc, pc_j, req, iv, old, oldj);
      end
      @(negedge Clk);
    end
    Stall = 0;
    checks++;
    if (pc !== old || req !== 1'b0 || iv !== 1'b0) begin
      failures++;
      $display("FAIL update: pc=%h req=%b iv=%b required pc=%h req=0 iv=0", pc, req, iv, old);
    end
    @(negedge Clk);
    mpc = r[31:0]; mpcj = rj[31:0]; msrc = r[32];
    checks++;
    if (pc !== mpc || pc_j !== mpcj || src !== msrc || src_j !== rj[32]) begin
      failures++;
      $display("FAIL commit: ins=%h pc=%h/%h pcsrc=%b/%b required pc=%h/%h pcsrc=%b", ins, pc, pc_j, src, src_j, mpc, mpcj, msrc);
    end
  endtask

  task automatic chk_reset(input string tag);
    checks++;
    if (req !== 0 || req_j !== 0 || iv !== 0 || pc !== 32'h0 || pc_j !== 32'h4000_0000 || ins_o !== 0 || src !== 0 || src_j !== 0) begin
      failures++;
      $display("FAIL %s: req=%b iv=%b pc=%h/%h instr=%h pcsrc=%b required req=0 iv=0 pc=00000000/40000000 instr=0 pcsrc=0",
               tag, req, iv, pc, pc_j, ins_o, src);
    end
  endtask

  task automatic release_reset();
    Reset = 1; #1;
    mpc = 32'h0; mpcj = 32'h4000_0000; msrc = 0;
  endtask

  task automatic test_reset();
    Reset = 0;
    repeat (2) @(negedge Clk);
    chk_reset("reset_state");
    release_reset();
  endtask

  task automatic test_beq_not_taken();
    do_instr({6'b000100, 5'd3, 5'd7, 16'h4321}, 2, 0, 1'b0, 0);
    checks++;
    if (pc !== 32'h0000_0004 || src !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken: pc=%h pcsrc=%b required 00000004 0", pc, src);
    end
  endtask

  task automatic test_beq_taken();
    do_instr(32'h0800_0000, 0, 0, 1'b0, 0);
    do_instr({6'b000100, 5'd1, 5'd2, 16'h1234}, 0, 1, 1'b1, 0);
    checks++;
    if (pc !== 32'h0000_48D4 || src !== 1'b1) begin
      failures++;
      $display("FAIL beq_taken: pc=%h pcsrc=%b required 000048d4 1", pc, src);
    end
  endtask

  task automatic test_loop();
    do_instr(32'h0800_0040, 1, 0, 1'b0, 0);
    do_instr({6'b000100, 5'd4, 5'd4, 16'hFFFF}, 0, 0, 1'b1, 0);
    checks++;
    if (pc !== 32'h0000_0100) begin
      failures++;
      $display("FAIL beq_loop: pc=%h required 00000100", pc);
    end
    do_instr({6'b000101, 5'd4, 5'd5, 16'h0020}, 0, 2, 1'b1, 0);
    checks++;
    if (pc !== 32'h0000_0104 || src !== 1'b0) begin
      failures++;
      $display("FAIL bne_not_taken: pc=%h pcsrc=%b required 00000104 0", pc, src);
    end
  endtask

  task automatic test_wrap_and_jump();
    do_instr(32'h0800_0000, 0, 0, 1'b0, 0);
    do_instr({6'b000100, 5'd0, 5'd0, 16'hFFFE}, 0, 0, 1'b1, 0);
    do_instr(32'h0128_4020, 0, 0, 1'b0, 0);
    checks++;
    if (pc !== 32'h0000_0000 || pc_j !== 32'h4000_0000) begin
      failures++;
      $display("FAIL pc_wrap: pc=%h/%h required 00000000/40000000", pc, pc_j);
    end
    do_instr(32'h0800_0010, 0, 0, 1'b0, 0);
    checks++;
    if (pc_j !== 32'h4000_0040 || pc !== 32'h0000_0040 || src_j !== 1'b1) begin
      failures++;
      $display("FAIL jump: pc=%h/%h pcsrc=%b required 00000040/40000040 1", pc, pc_j, src_j);
    end
  endtask

  task automatic test_stall();
    do_instr(32'h0000_0020, 0, 0, 1'b0, 5);
    do_instr({6'b000101, 5'd1, 5'd2, 16'h0008}, 1, 1, 1'b0, 5);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: op = 6'b000000;
        1: op = 6'b000010;
        2: op = 6'b000100;
        3: op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      do_instr({op, w[25:0]}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid(input bit at_zero);
    do_instr(32'h0800_0123, 0, 0, 1'b0, 0);
    IMemReady = 0;
    @(negedge Clk);
    if (at_zero) begin
      IMemReady = 1; IMemData = {6'b000100, 5'd1, 5'd1, 16'h0010};
      @(negedge Clk);
      IMemReady = 0; ZeroValid = 0;
      repeat (3) @(negedge Clk);
    end else begin
      repeat (2) @(negedge Clk);
    end
    Reset = 0; #1;
    chk_reset(at_zero ? "reset_wait_zero" : "reset_wait_mem");
    IMemReady = 1; ZeroValid = 1;
    @(negedge Clk);
    chk_reset(at_zero ? "reset_hold_wz" : "reset_hold_wm");
    IMemReady = 0; ZeroValid = 0;
    release_reset();
    do_instr(32'h0000_0000, 0, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_beq_not_taken();
    test_beq_taken();
    test_loop();
    test_wrap_and_jump();
    test_stall();
    test_random();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle controller that owns the program counter and sequences instruction fetch, next-PC selection and PC update for the MIPS core. It replaces the free-running PC register, PC+4 adder, branch adder and mux with a single FSM. The FSM handshakes with instruction memory, waits for the ALU Zero result on conditional branches, and commits exactly one next-PC per instruction. Downstream decode and datapath logic consume Instr/InstrValid.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BEQ_OP, 6'b000100, opcode of branch-if-equal (taken when Zero=1).
BNE_OP, 6'b000101, opcode of branch-if-not-equal (taken when Zero=0).
J_OP, 6'b000010, opcode of unconditional jump.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Stall  in  1  hold request; sampled only in UPDATE.
IMemReq  out  1  instruction fetch request.
IMemAddr  out  32  fetch address (equals PC).
IMemReady  in  1  memory returns IMemData this cycle.
IMemData  in  32  fetched instruction word.
Instr  out  32  latched current instruction.
InstrValid  out  1  one-cycle pulse in DECODE.
Zero  in  1  ALU zero flag for current instruction.
ZeroValid  in  1  Zero is meaningful this cycle.
PC  out  32  architectural program counter.
PCSrc  out  1  1 when the last commit took a branch or jump.

Behaviour:
- Reset low, asynchronous: state=FETCH, PC=RESET_PC, Instr=0, IMemReq=0, InstrValid=0, PCSrc=0. Mid-operation reset discards the outstanding fetch and any pending branch.
- States: FETCH, WAIT_MEM, DECODE, WAIT_ZERO, UPDATE.
- FETCH: IMemReq=1, IMemAddr=PC. Go to WAIT_MEM.
- WAIT_MEM: IMemReq remains 1. When IMemReady=1, latch Instr<=IMemData and go to DECODE. Otherwise stay, with no timeout.
- DECODE: InstrValid=1 for exactly this cycle. Compute PC4=PC+4, BT=PC4+(sext(Instr[15:0])<<2) and JT={PC4[31:28],Instr[25:0],2'b00}.
  - Opcode BEQ_OP or BNE_OP: go to WAIT_ZERO.
  - Otherwise: go to UPDATE with NextPC = JT if opcode==J_OP, else PC4.
- WAIT_ZERO: wait for ZeroValid=1.
  - BEQ_OP: taken = Zero.
  - BNE_OP: taken = ~Zero.
  - NextPC = taken ? BT : PC4. Go to UPDATE.
- UPDATE:
  - If Stall=1: hold. PC is unchanged and NextPC is retained.
  - Else: PC<=NextPC, PCSrc<=(taken or jump), go to FETCH.
- Latency: a non-branch instruction with zero memory wait takes 4 cycles (FETCH, WAIT_MEM, DECODE, UPDATE). An immediate ZeroValid adds 1 cycle.
- All arithmetic is unsigned 32-bit modulo 2^32. PC+4 and branch targets wrap silently, and the offset is two's-complement.
- PC changes only on the UPDATE to FETCH transition. IMemReq is never asserted outside FETCH/WAIT_MEM.
- Zero and ZeroValid are ignored outside WAIT_ZERO. IMemReady is ignored outside WAIT_MEM.
- Stall outside UPDATE has no effect.

Test Plan:
- Reset release, PC=0, Instr=beq imm 16'h4321, IMemReady after 2 cycles, ZeroValid=1 with Zero=0 -> PC=32'h0000_0004, PCSrc=0, and exactly 1 InstrValid pulse.
- PC=0, beq imm 16'h1234, Zero=1 -> PC=32'h0000_48D4, PCSrc=1.
- PC=32'h0000_0100, beq imm 16'hFFFF, Zero=1 -> PC=32'h0000_0100 (negative offset loop). Then bne with Zero=1 -> PC=32'h0000_0104.
- PC=32'hFFFF_FFFC, add instruction -> PC wraps to 32'h0000_0000. Jump Instr=32'h0800_0010 at PC=32'h4000_0000 -> PC=32'h4000_0040.
- Stall=1 for 5 cycles in UPDATE -> PC is held and IMemReq=0 throughout. PC updates 1 cycle after Stall falls.
- Reset asserted during WAIT_MEM and WAIT_ZERO -> outputs return to reset values immediately. After release, the first IMemAddr is RESET_PC.
